// File: rtl/fp32_mul_seq.sv
// Operand issuer / result collector for one fp32_mul instance; FP32_MUL_SEQ_STATS_EN adds stat_* counters.
// Latency: accept at t -> mul_op_vld t+1 -> m_vld t+2+MUL_LATENCY; 1 op/cycle sustained.
// Backpressure: s_rdy drops when in-flight + buffered results reach FIFO_DEPTH; m side is valid/ready.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_vld,
   input  logic [WIDTH-1:0]         wr_dat,
   output logic                     rd_vld,
   input  logic                     rd_rdy,
   output logic [WIDTH-1:0]         rd_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop;

   assign pop    = rd_vld && rd_rdy;
   assign rd_vld = (count != '0);
   // Output comes straight from storage registers; nothing bypasses wr_dat.
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({wr_vld, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_vld) mem[wr_ptr] <= wr_dat;
   end
endmodule

module fp32_mul_seq #(
   parameter int FIFO_DEPTH   = 16,
   parameter int MUL_LATENCY  = 8,
   parameter int DRAIN_CYCLES = MUL_LATENCY + 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_vld,
   output logic        s_rdy,
   input  logic [31:0] s_a,
   input  logic [31:0] s_b,
   output logic        mul_op_vld,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_result_vld,
   input  logic [31:0] mul_result,
   output logic        m_vld,
   input  logic        m_rdy,
   output logic [31:0] m_data,
   output logic        err
`ifdef FP32_MUL_SEQ_STATS_EN
   ,
   output logic [31:0]                   stat_issued,
   output logic [31:0]                   stat_stall,
   output logic [$clog2(FIFO_DEPTH):0]   stat_max_occ
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic {S_DRAIN, S_RUN} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] drain_cnt, drain_cnt_nxt;
   logic [CW-1:0] inflight;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occ;
   logic          run;
   logic          accept;
   logic          ret;
   logic          bad;

   // Credits: every accepted op owns a FIFO slot until its result is popped.
   assign occ    = {1'b0, inflight} + {1'b0, fifo_count};
   assign run    = (state == S_RUN);
   assign accept = s_vld && s_rdy;
   assign ret    = run && mul_result_vld && (inflight != '0);
   assign bad    = run && mul_result_vld && (inflight == '0);

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      s_rdy         = 1'b0;
      case (state)
         S_DRAIN: begin
            if (drain_cnt == '0) state_nxt = S_RUN;
            else                 drain_cnt_nxt = drain_cnt - DW'(1);
         end
         S_RUN: s_rdy = (occ < (CW+1)'(FIFO_DEPTH));
         default: state_nxt = S_DRAIN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_DRAIN;
         drain_cnt  <= DW'(DRAIN_CYCLES - 1);
         mul_op_vld <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         inflight   <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         drain_cnt  <= drain_cnt_nxt;
         mul_op_vld <= accept;
         if (accept) begin
            mul_a <= s_a;
            mul_b <= s_b;
         end
         case ({accept, ret})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         if (bad) err <= 1'b1;
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (ret),
      .wr_dat (mul_result),
      .rd_vld (m_vld),
      .rd_rdy (m_rdy),
      .rd_dat (m_data),
      .count  (fifo_count)
   );

`ifdef FP32_MUL_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued  <= '0;
         stat_stall   <= '0;
         stat_max_occ <= '0;
      end else begin
         if (accept)                   stat_issued <= stat_issued + 32'd1;
         if (run && s_vld && !s_rdy)   stat_stall  <= stat_stall + 32'd1;
         // occ never exceeds FIFO_DEPTH, so its low CW bits hold it exactly.
         if (occ[CW-1:0] > stat_max_occ) stat_max_occ <= occ[CW-1:0];
      end
   end
`endif
endmodule

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Initiator and collector for the fp32_mul pipeline.
- Accepts operand pairs from a valid/ready producer and issues them to the multiplier. The multiplier has no backpressure.
- Captures results into a local FIFO and returns them to a valid/ready consumer.
- Uses credit accounting so that no multiplier result is ever dropped. Sits between the path-tracer shading datapath and each fp32_mul instance.

Parameters:
- FIFO_DEPTH, 16, result FIFO entries; power of two, ≥ 4.
- MUL_LATENCY, 8, fixed fp32_mul pipeline latency in cycles; op_vld to result_vld.
- DRAIN_CYCLES, MUL_LATENCY+2, cycles spent discarding stale results after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_vld  in  1  operand pair valid.
- s_rdy  out  1  operand pair accepted when s_vld && s_rdy.
- s_a  in  32  fp32_t operand a.
- s_b  in  32  fp32_t operand b.
- mul_op_vld  out  1  to fp32_mul op_vld.
- mul_a  out  32  to fp32_mul a.
- mul_b  out  32  to fp32_mul b.
- mul_result_vld  in  1  from fp32_mul result_vld.
- mul_result  in  32  from fp32_mul result.
- m_vld  out  1  product valid.
- m_rdy  in  1  consumer ready.
- m_data  out  32  fp32_t product.
- err  out  1  sticky; set on an unexpected mul_result_vld.

Behaviour:
- Reset values: s_rdy=0, mul_op_vld=0, mul_a=0, mul_b=0, m_vld=0, m_data=0, err=0, in-flight=0, FIFO empty, state=DRAIN, drain counter=DRAIN_CYCLES-1.
- State DRAIN:
  - s_rdy=0; mul_result_vld is ignored, since the multiplier pipeline is not reset.
  - Drain counter decrements each cycle; at 0, transition to RUN.
  - err is not set during DRAIN.
- State RUN:
  - s_rdy = (inflight + fifo_count) < FIFO_DEPTH. This is combinational from registers only, with no dependence on s_vld.
  - Accept: mul_op_vld, mul_a and mul_b are registered from s_vld&&s_rdy, s_a and s_b on the next cycle. Otherwise mul_op_vld=0 and mul_a/mul_b hold their values.
  - inflight is incremented on accept, in the same cycle s_rdy is sampled. It covers the issue register plus the multiplier pipeline. Width is clog2(FIFO_DEPTH)+1.
  - mul_result_vld && inflight!=0: write mul_result into the FIFO; inflight decrements.
  - mul_result_vld && inflight==0: set err, discard the data, counters unchanged.
  - Accept and return in the same cycle: inflight is unchanged.
- FIFO:
  - Registered output, no fall-through.
  - Write at cycle t makes m_vld visible at t+1 at the earliest.
  - Pop on m_vld && m_rdy.
  - Simultaneous push and pop while full cannot happen, because credits guarantee count+inflight ≤ FIFO_DEPTH.
  - Simultaneous push and pop at count==1 keeps m_vld=1 with the new data.
  - m_data holds stable while m_vld && !m_rdy.
- Minimum latency: accept at cycle t → mul_op_vld at t+1 → result at t+1+MUL_LATENCY → m_vld at t+2+MUL_LATENCY.
- Throughput: 1 op/cycle sustained when m_rdy=1.
- Ordering: strict FIFO order; results leave in accept order.
- Reset mid-operation: all in-flight and buffered results are lost. The block re-enters DRAIN, and stale results emerging during DRAIN are discarded silently.

Optional Feature:
- Macro FP32_MUL_SEQ_STATS_EN. When defined, the block adds three outputs:
  - stat_issued, 32 bits: count of accepts.
  - stat_stall, 32 bits: cycles in RUN with s_vld && !s_rdy.
  - stat_max_occ, clog2(FIFO_DEPTH)+1 bits: high-water mark of inflight+fifo_count.
- All three counters clear on rst, and the two 32-bit counters wrap.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then assert s_vld constantly → s_rdy stays 0 for exactly DRAIN_CYCLES (10) cycles and then rises. A mul_result_vld pulse injected at cycle 3 of DRAIN produces no m_vld and no err.
- Single op, defaults: s_a=0x40000000 (2.0), s_b=0x40400000 (3.0), accepted at cycle t → mul_op_vld at t+1, m_vld at t+10 with m_data=0x40C00000 (6.0).
- Hold m_rdy=0 and stream 20 ops → exactly 16 accepts, then s_rdy=0. Release m_rdy → 16 results in order, s_rdy reasserts the cycle after the first pop, no result lost.
- Stream 100 ops with m_rdy toggling 1/0 every cycle → 100 products in order, values 1.0×k = k for k=1..100, no gaps or duplicates.
- Force mul_result_vld=1 in RUN with inflight=0 → err=1 and stays 1. FIFO count unchanged.
- Assert rst with 5 ops in flight and 3 buffered → all outputs return to reset values next cycle, DRAIN re-entered, and stale results are discarded.
